// File: rtl/sync_count_pkg.sv
// Shared types for the counter monitor: FSM state encoding and the all-ones count helper.
package sync_count_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   function automatic int unsigned CNT_MAX(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/sync_count_wrap_ctr.sv
// Saturating wrap-event counter: counts inc pulses, holds at all-ones and raises a sticky sat flag.
module sync_count_wrap_ctr #(
   parameter int WRAP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              clr,
   output logic [WRAP_W-1:0] cnt,
   output logic              sat
);

   localparam logic [WRAP_W-1:0] CNT_TOP = '1;

   logic [WRAP_W-1:0] cnt_q, cnt_d;
   logic              sat_q, sat_d;

   always_comb begin
      cnt_d = cnt_q;
      sat_d = sat_q;
      if (clr) begin
         cnt_d = '0;
         sat_d = 1'b0;
      end else begin
         if (inc && cnt_q != CNT_TOP) cnt_d = cnt_q + 1'b1;
         sat_d = sat_q | (cnt_d == CNT_TOP);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         sat_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sat_q <= sat_d;
      end
   end

   assign cnt = cnt_q;
   assign sat = sat_q;

endmodule

// File: rtl/sync_count_monitor.sv
// Rollover monitor for an up/down counter: wrap tick/direction/count, hysteresis flag, and an
// optional illegal-step checker enabled by SYNC_COUNT_MONITOR_STEP_CHECK_EN.
//
//  state | meaning
//  IDLE  | no previous sample held; next en only captures
//  TRACK | comparing each sample against the previous one
//  FAULT | illegal step seen; wrap logic frozen until clr
module sync_count_monitor
   import sync_count_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int WRAP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic [WIDTH-1:0]  cnt,
   input  logic              up,
   input  logic [WIDTH-1:0]  thr_hi,
   input  logic [WIDTH-1:0]  thr_lo,
   output logic              tick,
   output logic              wrap_dir,
   output logic [WRAP_W-1:0] wrap_cnt,
   output logic              wrap_sat,
   output logic              above,
   output logic              step_err,
   output logic              fault
);

   localparam logic [WIDTH-1:0] MAX = WIDTH'(CNT_MAX(WIDTH));

   state_t           state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic             up_prev_q, up_prev_d;
   logic             tick_q, tick_d;
   logic             wrap_dir_q, wrap_dir_d;
   logic             above_q, above_d;
   logic             step_err_q, step_err_d;
   logic             fault_q, fault_d;
   logic             wrap_inc;
   logic             up_wrap, dn_wrap, step_bad;

   // Wraps are judged against the direction that produced cnt, i.e. the previous sample's up.
   assign up_wrap = up_prev_q && (prev_q == MAX) && (cnt == '0);
   assign dn_wrap = !up_prev_q && (prev_q == '0) && (cnt == MAX);

`ifdef SYNC_COUNT_MONITOR_STEP_CHECK_EN
   logic [WIDTH-1:0] delta;
   assign delta    = cnt - prev_q;
   assign step_bad = !((delta == '0) ||
                       (up_prev_q && delta == WIDTH'(1)) ||
                       (!up_prev_q && delta == MAX));
`else
   assign step_bad = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      prev_d     = prev_q;
      up_prev_d  = up_prev_q;
      tick_d     = 1'b0;
      wrap_dir_d = wrap_dir_q;
      above_d    = above_q;
      step_err_d = 1'b0;
      fault_d    = fault_q;
      wrap_inc   = 1'b0;
      if (clr) begin
         state_d = IDLE;
         above_d = 1'b0;
         fault_d = 1'b0;
      end else if (en) begin
         // Set wins when both thresholds are satisfied.
         if (cnt >= thr_hi)      above_d = 1'b1;
         else if (cnt <= thr_lo) above_d = 1'b0;
         case (state_q)
            IDLE: begin
               prev_d    = cnt;
               up_prev_d = up;
               state_d   = TRACK;
            end
            TRACK: begin
               prev_d    = cnt;
               up_prev_d = up;
               if (step_bad) begin
                  step_err_d = 1'b1;
                  fault_d    = 1'b1;
                  state_d    = FAULT;
               end else if (up_wrap || dn_wrap) begin
                  tick_d     = 1'b1;
                  wrap_dir_d = up_wrap;
                  wrap_inc   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         prev_q     <= '0;
         up_prev_q  <= 1'b0;
         tick_q     <= 1'b0;
         wrap_dir_q <= 1'b0;
         above_q    <= 1'b0;
         step_err_q <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         up_prev_q  <= up_prev_d;
         tick_q     <= tick_d;
         wrap_dir_q <= wrap_dir_d;
         above_q    <= above_d;
         step_err_q <= step_err_d;
         fault_q    <= fault_d;
      end
   end

   sync_count_wrap_ctr #(.WRAP_W(WRAP_W)) u_wrap_ctr (
      .clk (clk),
      .rst (rst),
      .inc (wrap_inc),
      .clr (clr),
      .cnt (wrap_cnt),
      .sat (wrap_sat)
   );

   assign tick     = tick_q;
   assign wrap_dir = wrap_dir_q;
   assign above    = above_q;
   assign step_err = step_err_q;
   assign fault    = fault_q;

endmodule

// File: tb/tb_sync_count_monitor.sv
// Bench for sync_count_monitor: reference model feeds a scoreboard queue, plus a hand-built vector table.
module tb_sync_count_monitor;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0, clr = 1'b0, up = 1'b0;
   logic [3:0] cnt = '0, thr_hi = 4'd12, thr_lo = 4'd3;

   logic       tick, wrap_dir, wrap_sat, above, step_err, fault;
   logic [7:0] wrap_cnt;
   logic       tick2, wrap_dir2, wrap_sat2, above2, step_err2, fault2;
   logic [1:0] wrap_cnt2;

   always #5 clk = ~clk;

   sync_count_monitor #(.WIDTH(4), .WRAP_W(8)) u_dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .cnt(cnt), .up(up),
      .thr_hi(thr_hi), .thr_lo(thr_lo), .tick(tick), .wrap_dir(wrap_dir),
      .wrap_cnt(wrap_cnt), .wrap_sat(wrap_sat), .above(above),
      .step_err(step_err), .fault(fault));

   sync_count_monitor #(.WIDTH(4), .WRAP_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .cnt(cnt), .up(up),
      .thr_hi(thr_hi), .thr_lo(thr_lo), .tick(tick2), .wrap_dir(wrap_dir2),
      .wrap_cnt(wrap_cnt2), .wrap_sat(wrap_sat2), .above(above2),
      .step_err(step_err2), .fault(fault2));

   typedef struct {
      int tick, dir, wcnt, sat, wcnt2, sat2, above, serr, fault;
   } exp_t;

   typedef struct {
      logic       en, clr;
      logic [3:0] cnt;
      logic       up;
      logic [3:0] hi, lo;
      int         tick, dir, wcnt, above;
   } vec_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // reference model state: 0 idle, 1 track, 2 fault
   int m_state, m_prev, m_upp, m_dir, m_wraps, m_above, m_fault;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_prev = 0; m_upp = 0; m_dir = 0;
      m_wraps = 0; m_above = 0; m_fault = 0;
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic step(input logic e, input logic c, input int v, input logic u);
      exp_t x;
      int   t = 0, se = 0, legal;
      en = e; clr = c; cnt = 4'(v); up = u;
      if (c) begin
         m_state = 0; m_wraps = 0; m_above = 0; m_fault = 0;
      end else if (e) begin
         if (v >= int'(thr_hi))      m_above = 1;
         else if (v <= int'(thr_lo)) m_above = 0;
         if (m_state == 0) begin
            m_prev = v; m_upp = u; m_state = 1;
         end else if (m_state == 1) begin
            legal = 1;
`ifdef SYNC_COUNT_MONITOR_STEP_CHECK_EN
            legal = (v == m_prev) ||
                    (m_upp == 1 && v == (m_prev + 1) % 16) ||
                    (m_upp == 0 && v == (m_prev + 15) % 16);
`endif
            if (legal == 0) begin
               se = 1; m_fault = 1; m_state = 2;
            end else if (m_upp == 1 && m_prev == 15 && v == 0) begin
               t = 1; m_dir = 1; m_wraps++;
            end else if (m_upp == 0 && m_prev == 0 && v == 15) begin
               t = 1; m_dir = 0; m_wraps++;
            end
            m_prev = v; m_upp = u;
         end
      end
      x.tick = t; x.dir = m_dir; x.above = m_above; x.serr = se; x.fault = m_fault;
      x.wcnt  = imin(m_wraps, 255); x.sat  = (m_wraps >= 255) ? 1 : 0;
      x.wcnt2 = imin(m_wraps, 3);   x.sat2 = (m_wraps >= 3) ? 1 : 0;
      sb_q.push_back(x);
      @(posedge clk);
      #1;
      x = sb_q.pop_front();
      chk("tick", int'(tick), x.tick);
      chk("wrap_dir", int'(wrap_dir), x.dir);
      chk("wrap_cnt", int'(wrap_cnt), x.wcnt);
      chk("wrap_sat", int'(wrap_sat), x.sat);
      chk("wrap_cnt_w2", int'(wrap_cnt2), x.wcnt2);
      chk("wrap_sat_w2", int'(wrap_sat2), x.sat2);
      chk("above", int'(above), x.above);
      chk("step_err", int'(step_err), x.serr);
      chk("fault", int'(fault), x.fault);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_tick"}, int'(tick), 0);
      chk({tag, "_wrap_dir"}, int'(wrap_dir), 0);
      chk({tag, "_wrap_cnt"}, int'(wrap_cnt), 0);
      chk({tag, "_wrap_sat"}, int'(wrap_sat), 0);
      chk({tag, "_above"}, int'(above), 0);
      chk({tag, "_step_err"}, int'(step_err), 0);
      chk({tag, "_fault"}, int'(fault), 0);
      chk({tag, "_wrap_cnt_w2"}, int'(wrap_cnt2), 0);
      chk({tag, "_wrap_sat_w2"}, int'(wrap_sat2), 0);
   endtask

   task automatic pulse_reset();
      #2 rst = 1'b0;
      #1 check_all_zero("rst_async");
      model_reset();
      #3 rst = 1'b1;
   endtask

   vec_t vt[14];

   initial begin
      vt[0]  = '{1, 0, 14, 1, 12,  3, 0, 0, 0, 1};
      vt[1]  = '{1, 0, 15, 0, 12,  3, 0, 0, 0, 1};
      vt[2]  = '{1, 0, 15, 1, 12,  3, 0, 0, 0, 1};
      vt[3]  = '{1, 0,  0, 1, 12,  3, 1, 1, 1, 0};
      vt[4]  = '{0, 0,  5, 1, 12,  3, 0, 1, 1, 0};
      vt[5]  = '{1, 0,  0, 0, 12,  3, 0, 1, 1, 0};
      vt[6]  = '{1, 0, 15, 0, 12,  3, 1, 0, 2, 1};
      vt[7]  = '{1, 0, 14, 0, 12,  3, 0, 0, 2, 1};
      vt[8]  = '{1, 0, 13, 0, 14, 13, 0, 0, 2, 0};
      vt[9]  = '{1, 0, 12, 0, 12, 12, 0, 0, 2, 1};
      vt[10] = '{1, 0, 11, 0, 12,  3, 0, 0, 2, 1};
      vt[11] = '{1, 1, 10, 0, 12,  3, 0, 0, 0, 0};
      vt[12] = '{1, 0, 15, 0, 12,  3, 0, 0, 0, 1};
      vt[13] = '{1, 0, 14, 0, 12,  3, 0, 0, 0, 1};

      model_reset();
      repeat (2) @(posedge clk);
      #1 check_all_zero("reset");
      @(negedge clk) rst = 1'b1;

      // up ramp 0..15,0..15,0,1 with hysteresis 12/3
      for (int r = 0; r < 2; r++)
         for (int v = 0; v < 16; v++) step(1, 0, v, 1);
      step(1, 0, 0, 1);
      step(1, 0, 1, 1);
      chk("up_ramp_wraps", int'(wrap_cnt), 2);

      // down ramp from a clean IDLE
      step(0, 1, 0, 0);
      for (int v = 15; v >= 0; v--) step(1, 0, v, 0);
      step(1, 0, 15, 0);
      chk("down_ramp_wraps", int'(wrap_cnt), 1);
      chk("down_ramp_dir", int'(wrap_dir), 0);

      // five up-wraps saturate the 2-bit counter; clr then first sample is capture only
      step(0, 1, 0, 1);
      for (int r = 0; r < 5; r++)
         for (int v = 0; v < 16; v++) step(1, 0, v, 1);
      step(1, 0, 0, 1);
      chk("sat_w2_cnt", int'(wrap_cnt2), 3);
      chk("sat_w2_flag", int'(wrap_sat2), 1);
      step(1, 0, 15, 1);
      step(1, 1, 3, 1);
      step(1, 0, 0, 1);
      step(1, 0, 1, 1);

      // step check: 4,5,9 then 15->0, then clr recovery
      step(0, 1, 0, 1);
      step(1, 0, 4, 1);
      step(1, 0, 5, 1);
      step(1, 0, 9, 1);
      step(1, 0, 15, 1);
      step(1, 0, 0, 1);
      step(0, 0, 1, 1);
      step(0, 1, 0, 1);
      step(1, 0, 15, 1);
      step(1, 0, 0, 1);

      // clr coincident with the 15->0 sample discards it
      step(0, 1, 0, 1);
      step(1, 0, 14, 1);
      step(1, 0, 15, 1);
      step(1, 1, 0, 1);
      chk("clr_on_wrap_cnt", int'(wrap_cnt), 0);

      // async reset mid-ramp, then first sample afterwards is capture only
      for (int v = 0; v <= 7; v++) step(1, 0, v, 1);
      pulse_reset();
      step(1, 0, 8, 1);
      step(1, 0, 9, 1);

      // vector table from a fresh reset
      pulse_reset();
      for (int i = 0; i < 14; i++) begin
         thr_hi = vt[i].hi;
         thr_lo = vt[i].lo;
         step(vt[i].en, vt[i].clr, int'(vt[i].cnt), vt[i].up);
         chk($sformatf("vec%0d_tick", i), int'(tick), vt[i].tick);
         chk($sformatf("vec%0d_dir", i), int'(wrap_dir), vt[i].dir);
         chk($sformatf("vec%0d_wcnt", i), int'(wrap_cnt), vt[i].wcnt);
         chk($sformatf("vec%0d_above", i), int'(above), vt[i].above);
      end

      chk("scoreboard_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
